// File: rtl/player_action_tx.sv
// -----------------------------------------------------------------------------
// player_action_tx
// -----------------------------------------------------------------------------
// Remote-pad end of the player action link. Serialises the player's 3-bit
// action code into 10-bit UART-style frames (start, 8 data bits LSB first,
// stop) on a single idle-high wire. A frame is launched whenever the action
// differs from the last one sent, and a keepalive frame is launched every
// FRAME_PERIOD cycles so the receiving server can detect a dead cable.
//
// Payload byte:
//   [2:0] action   [4:3] sequence number of this frame   [5] player_id
//   [6]   frame marker (always 1)   [7] parity bit
//
// Optional feature macro: PLAYER_ACTION_TX_PARITY_EN
//   defined   : bit[7] = ^bit[6:0] (even parity over the whole byte)
//   undefined : bit[7] = 0
//   Frame length and timing are the same either way.
//
// Parameters:
//   BAUD_DIV     - clock cycles per line bit (default 100 MHz / 115200)
//   FRAME_PERIOD - keepalive interval in clock cycles (default 60 Hz)
//
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous, active-high reset (historic port name)
//   action    in   [2:0] debounced action code, compared every IDLE cycle
//   player_id in   0 = player1, 1 = player2, sampled at frame launch
//   tx        out  serial line, idle high (registered)
//   busy      out  high while a frame is on the line (registered)
//   seq       out  [1:0] sequence number of the most recently launched frame
// -----------------------------------------------------------------------------
module player_action_tx #(
  parameter int unsigned BAUD_DIV     = 868,
  parameter int unsigned FRAME_PERIOD = 1666667
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] action,
  input  logic       player_id,
  output logic       tx,
  output logic       busy,
  output logic [1:0] seq
);

  // Counter widths: wide enough for the largest value each counter holds.
  localparam int unsigned BAUD_W  = (BAUD_DIV > 1)     ? $clog2(BAUD_DIV)     : 1;
  localparam int unsigned TIMER_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

  localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(BAUD_DIV - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FRAME_PERIOD - 1);
  localparam logic [BAUD_W-1:0]  BAUD_ONE   = BAUD_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

`ifdef PLAYER_ACTION_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // Bit 7 of the payload: even parity over the low seven bits when enabled,
  // otherwise forced to zero.
  function automatic logic parity_bit(input logic [6:0] low_bits);
    return PARITY_EN & (^low_bits);
  endfunction

  state_e              state_q;
  logic [BAUD_W-1:0]   baud_cnt_q;
  logic [2:0]          bit_idx_q;
  logic [7:0]          byte_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [2:0]          last_sent_q;
  logic [1:0]          seq_q;
  logic                tx_q;
  logic                busy_q;

  logic [1:0]          seq_d;
  logic [6:0]          payload_low_d;
  logic [7:0]          payload_d;
  logic                period_hit_s;
  logic                launch_s;
  logic                baud_end_s;

  // Launch decision and next payload byte, evaluated from the present state.
  always_comb begin
    seq_d         = seq_q + 2'd1;
    payload_low_d = {1'b1, player_id, seq_d, action};
    payload_d     = {parity_bit(payload_low_d), payload_low_d};
    period_hit_s  = (timer_q == TIMER_LAST);
    baud_end_s    = (baud_cnt_q == BAUD_LAST);
    // A change and a keepalive arriving together still make only one frame.
    if (state_q == S_IDLE) begin
      launch_s = (action != last_sent_q) || period_hit_s;
    end else begin
      launch_s = 1'b0;
    end
  end

  // Frame FSM, period timer and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= 3'd0;
      byte_q      <= 8'h00;
      timer_q     <= '0;
      last_sent_q <= 3'b000;
      seq_q       <= 2'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      // Outputs follow the state one cycle later, so tx falls and busy rises
      // on the edge after the launch edge and each bit still lasts BAUD_DIV.
      case (state_q)
        S_IDLE:  tx_q <= 1'b1;
        S_START: tx_q <= 1'b0;
        S_DATA:  tx_q <= byte_q[bit_idx_q];
        S_STOP:  tx_q <= 1'b1;
        default: tx_q <= 1'b1;
      endcase
      busy_q <= (state_q != S_IDLE);

      // The timer restarts on every launch; while a frame is in flight it
      // parks at the last value so an overdue keepalive fires on return to IDLE.
      if (launch_s) begin
        timer_q <= '0;
      end else if (timer_q != TIMER_LAST) begin
        timer_q <= timer_q + TIMER_ONE;
      end else begin
        timer_q <= timer_q;
      end

      case (state_q)
        S_IDLE: begin
          baud_cnt_q <= '0;
          bit_idx_q  <= 3'd0;
          if (launch_s) begin
            byte_q      <= payload_d;
            last_sent_q <= action;
            seq_q       <= seq_d;
            state_q     <= S_START;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_START: begin
          if (baud_end_s) begin
            baud_cnt_q <= '0;
            state_q    <= S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_ONE;
          end
        end

        S_DATA: begin
          if (baud_end_s) begin
            baud_cnt_q <= '0;
            // Index wraps 7 -> 0 on the way out of DATA.
            bit_idx_q  <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_ONE;
          end
        end

        S_STOP: begin
          // Always pass through IDLE; a new launch is never taken from STOP.
          if (baud_end_s) begin
            baud_cnt_q <= '0;
            state_q    <= S_IDLE;
          end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_ONE;
          end
        end

        default: begin
          baud_cnt_q <= '0;
          bit_idx_q  <= 3'd0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign seq  = seq_q;

endmodule
